// File: rtl/twi_bus_frontend.sv
// I2C pin front end: synchronise, deglitch and decode SCL/SDA into clk-domain bus events.
// Optional SCL-stuck-low timeout is built when TWI_BUS_FRONTEND_TIMEOUT_EN is defined.
module twi_bus_frontend #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [3:0] bit_cnt,
    output logic       ack_slot,
    output logic       ack_bit,
    output logic       timeout
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s;
    logic [FW-1:0]          scl_cnt, sda_cnt, scl_cnt_nxt, sda_cnt_nxt;
    logic                   scl_f_nxt, sda_f_nxt;
    logic                   rise_nxt, fall_nxt, start_nxt, stop_nxt;
    logic                   ack_slot_nxt, ack_bit_nxt;
    logic [3:0]             bit_cnt_nxt;
    logic                   tmo_hit;

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign bus_busy = (state == BUSY);

    // A filtered line moves only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        scl_cnt_nxt = '0;
        scl_f_nxt   = scl_f;
        if (scl_s != scl_f) begin
            if (scl_cnt == FLT_LAST) scl_f_nxt = scl_s;
            else                     scl_cnt_nxt = scl_cnt + 1'b1;
        end
        sda_cnt_nxt = '0;
        sda_f_nxt   = sda_f;
        if (sda_s != sda_f) begin
            if (sda_cnt == FLT_LAST) sda_f_nxt = sda_s;
            else                     sda_cnt_nxt = sda_cnt + 1'b1;
        end
    end

    // Events are decoded from the upcoming filtered values so strobes align with the line change.
    always_comb begin
        rise_nxt  = ~scl_f & scl_f_nxt;
        fall_nxt  = scl_f & ~scl_f_nxt;
        start_nxt = scl_f & scl_f_nxt & sda_f & ~sda_f_nxt;
        stop_nxt  = scl_f & scl_f_nxt & ~sda_f & sda_f_nxt;
    end

`ifdef TWI_BUS_FRONTEND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;

    always_comb begin
        tmo_hit     = 1'b0;
        tmo_cnt_nxt = '0;
        if (state == BUSY && !scl_f) begin
            if (tmo_cnt == TMO_LAST) tmo_hit = 1'b1;
            else                     tmo_cnt_nxt = tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tmo_cnt <= '0;
        else        tmo_cnt <= tmo_cnt_nxt;
    end
`else
    assign tmo_hit = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        ack_slot_nxt = 1'b0;
        ack_bit_nxt  = ack_bit;
        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (start_nxt) state_nxt = BUSY;
            end
            BUSY: begin
                if (tmo_hit) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end else if (start_nxt) begin
                    bit_cnt_nxt = '0;
                end else if (stop_nxt) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end else if (rise_nxt) begin
                    if (bit_cnt == 4'd8) begin
                        ack_slot_nxt = 1'b1;
                        ack_bit_nxt  = sda_f_nxt;
                        bit_cnt_nxt  = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_cnt   <= '0;
            sda_cnt   <= '0;
            scl_f     <= 1'b1;
            sda_f     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            ack_slot  <= 1'b0;
            ack_bit   <= 1'b0;
            timeout   <= 1'b0;
            bit_cnt   <= '0;
            state     <= IDLE;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_cnt   <= scl_cnt_nxt;
            sda_cnt   <= sda_cnt_nxt;
            scl_f     <= scl_f_nxt;
            sda_f     <= sda_f_nxt;
            scl_rise  <= rise_nxt;
            scl_fall  <= fall_nxt;
            start_det <= start_nxt;
            stop_det  <= stop_nxt;
            ack_slot  <= ack_slot_nxt;
            ack_bit   <= ack_bit_nxt;
            timeout   <= tmo_hit;
            bit_cnt   <= bit_cnt_nxt;
            state     <= state_nxt;
        end
    end

endmodule

// File: tb/tb_twi_bus_frontend.sv
// Scoreboard bench for twi_bus_frontend: a window-based line model predicts events into a queue.
module tb_twi_bus_frontend;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TMO  = 100;
    localparam int D    = SYNC + FILT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic       bus_busy, ack_slot, ack_bit, timeout;
    logic [3:0] bit_cnt;

    always #5 clk = ~clk;

    twi_bus_frontend #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_f    (scl_f),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .bus_busy (bus_busy),
        .bit_cnt  (bit_cnt),
        .ack_slot (ack_slot),
        .ack_bit  (ack_bit),
        .timeout  (timeout)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         cyc;
        logic [5:0] str;   // rise, fall, start, stop, ack_slot, timeout
        logic       busy;
        logic [3:0] bits;
        logic       ackb;
    } ev_t;

    ev_t          q[$];
    int           cyc = 0;
    logic [D-1:0] hs = '1, hd = '1;   // pin samples per edge, newest at bit 0
    logic         m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0, m_ackb = 1'b0;
    int           m_rises = 0;        // SCL rises since the last START
    logic         ns, nd, rise, fall, st, sp, ack, tmo;
`ifdef TWI_BUS_FRONTEND_TIMEOUT_EN
    int           m_run = 0;          // consecutive busy cycles with SCL low
`endif

    // A line takes a new level once FILT consecutive samples, delayed by SYNC, all agree on it.
    function automatic logic filt_next(input logic [D-1:0] h, input logic cur);
        logic [FILT-1:0] w;
        w = h[D-1:SYNC];
        if (w == '1) return 1'b1;
        if (w == '0) return 1'b0;
        return cur;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            hs = '1; hd = '1;
            m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0; m_ackb = 1'b0; m_rises = 0;
`ifdef TWI_BUS_FRONTEND_TIMEOUT_EN
            m_run = 0;
`endif
        end else begin
            hs = {hs[D-2:0], scl_in};
            hd = {hd[D-2:0], sda_in};
            ns = filt_next(hs, m_scl);
            nd = filt_next(hd, m_sda);
            rise = !m_scl && ns;
            fall = m_scl && !ns;
            st   = m_scl && ns && m_sda && !nd;
            sp   = m_scl && ns && !m_sda && nd;
            ack  = 1'b0;
            tmo  = 1'b0;
`ifdef TWI_BUS_FRONTEND_TIMEOUT_EN
            m_run = (m_busy && !m_scl) ? m_run + 1 : 0;
            if (m_run == TMO) begin
                tmo = 1'b1;
                m_run = 0;
            end
`endif
            if (tmo) m_busy = 1'b0;
            else if (st) begin
                m_busy = 1'b1;
                m_rises = 0;
            end else if (sp) m_busy = 1'b0;
            else if (m_busy && rise) begin
                m_rises++;
                if (m_rises % 9 == 0) begin
                    ack = 1'b1;
                    m_ackb = nd;
                end
            end
            if (!m_busy) m_rises = 0;
            m_scl = ns;
            m_sda = nd;
            if (rise || fall || st || sp || ack || tmo)
                q.push_back('{cyc, {rise, fall, st, sp, ack, tmo}, m_busy, 4'(m_rises % 9), m_ackb});
        end
    end

    // ---------------- monitor ----------------
    logic [5:0] mon_str;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_str = {scl_rise, scl_fall, start_det, stop_det, ack_slot, timeout};
            if (mon_str != 6'b0) begin
                if (q.size() == 0) check("unexpected_strobe", int'(mon_str), 0);
                else begin
                    mon_e = q.pop_front();
                    check("event_cycle", cyc, mon_e.cyc);
                    check("event_strobes", int'(mon_str), int'(mon_e.str));
                    check("event_state", int'({bus_busy, bit_cnt, ack_bit}),
                          int'({mon_e.busy, mon_e.bits, mon_e.ackb}));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e = q.pop_front();
                check("missing_event", 0, int'(mon_e.str));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic s, input logic d, input int n);
        scl_in = s;
        sda_in = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_levels(input string tag);
        check({tag, "_scl_f"}, scl_f, m_scl);
        check({tag, "_sda_f"}, sda_f, m_sda);
        check({tag, "_busy"}, bus_busy, m_busy);
        check({tag, "_bit_cnt"}, bit_cnt, m_rises % 9);
    endtask

    // One data/ack bit; optional SCL glitch of glen (<FILT) cycles inside the high phase.
    task automatic send_bit(input logic b, input int glen);
        drive(1'b0, sda_in, 5);
        drive(1'b0, b, 15);
        if (glen > 0) begin
            drive(1'b1, b, 8);
            drive(1'b0, b, glen);
            drive(1'b1, b, 12 - glen);
        end else drive(1'b1, b, 20);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic ackv, input int glen);
        for (int i = 0; i < 8; i++) send_bit(data[7-i], glen);
        send_bit(ackv, 0);
    endtask

    task automatic start_cond();
        drive(1'b0, 1'b1, 10);
        drive(1'b1, 1'b1, 20);
        drive(1'b1, 1'b0, 20);
        drive(1'b0, 1'b0, 10);
    endtask

    task automatic stop_cond();
        drive(1'b0, 1'b0, 10);
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        // Reset with idle pins
        drive(1'b1, 1'b1, 3);
        check("reset_lines", int'({scl_f, sda_f}), 3);
        check("reset_outputs", int'({scl_rise, scl_fall, start_det, stop_det, bus_busy,
                                     bit_cnt, ack_slot, ack_bit, timeout}), 0);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 10);

        // Short SDA pulse must be swallowed
        drive(1'b1, 1'b0, 3);
        drive(1'b1, 1'b1, 12);
        check("glitch_sda_f", sda_f, 1);
        check("glitch_busy", bus_busy, 0);

        // 4-cycle SDA low: filtered fall exactly 6 cycles after the pin edge
        drive(1'b1, 1'b0, 5);
        check("lat_before", sda_f, 1);
        drive(1'b1, 1'b0, 1);
        check("lat_sda_f", sda_f, 0);
        check("lat_start", start_det, 1);
        check("lat_busy", bus_busy, 1);
        drive(1'b1, 1'b0, 14);
        drive(1'b0, 1'b0, 20);

        // Byte 0xA5 with ACK
        send_byte(8'hA5, 1'b0, 0);
        drive(1'b0, sda_in, 10);
        check("byte_ack_bit", ack_bit, 0);
        check("byte_bit_cnt", bit_cnt, 0);
        check_levels("byte");

        // Repeated START after 3 bits, then STOP
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 0);
        start_cond();
        check("rstart_busy", bus_busy, 1);
        check("rstart_bit_cnt", bit_cnt, 0);
        for (int t = 0; t < 2; t++)
            send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
        stop_cond();
        check("stop_busy", bus_busy, 0);
        check_levels("stop");

        // SCL and SDA fall together: no START
        drive(1'b1, 1'b1, 20);
        drive(1'b0, 1'b0, 20);
        check("same_edge_busy", bus_busy, 0);
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);   // STOP on an idle bus
        check_levels("same_edge");

        // Randomised transactions with rejected SCL glitches
        for (int t = 0; t < 4; t++) begin
            start_cond();
            for (int b = 0; b < int'($urandom_range(1, 3)); b++)
                send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, FILT - 1)));
            stop_cond();
            check_levels("rand");
        end

        // Reset in the middle of a byte aborts silently
        start_cond();
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 0);
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 3);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 20);
        check("abort_busy", bus_busy, 0);
        check("abort_bit_cnt", bit_cnt, 0);

        // SCL held low after START
        start_cond();
`ifdef TWI_BUS_FRONTEND_TIMEOUT_EN
        drive(1'b0, 1'b0, 300);
        check("tmo_busy", bus_busy, 0);
`else
        drive(1'b0, 1'b0, 1000);
        check("tmo_busy", bus_busy, 1);
        check("tmo_level", timeout, 0);
`endif
        check_levels("tmo");
        stop_cond();
        drive(1'b1, 1'b1, 20);
        check_levels("end");

        check("queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
